fetch_unit: RTL
===============

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000, giving the fetch address after reset.
REQ-002 The block SHALL have parameter QDEPTH, default 2, giving the number of instruction-queue entries (legal range 1..4).
REQ-003 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1: the reset; asynchronous, active-low.
REQ-005 Port branch_taken, input, 1: redirect request from the execute stage.
REQ-006 Port branch_target, input, 32: redirect address; bits [1:0] are ignored and treated as 00.
REQ-007 Port imem_req, output, 1: instruction-memory request (registered).
REQ-008 Port imem_addr, output, 32: word address for the request (registered).
REQ-009 Port imem_ack, input, 1: single-cycle response strobe; legal only while imem_req=1.
REQ-010 Port imem_rdata, input, 32: instruction word, valid when imem_ack=1.
REQ-011 Port id_valid, output, 1: queue head holds a valid instruction.
REQ-012 Port id_instr, output, 32: instruction at the queue head.
REQ-013 Port id_pc, output, 32: address of the instruction at the queue head.
REQ-014 Port id_ready, input, 1: the decode stage accepts the head this cycle.
REQ-015 Port pc_out, output, 32: current fetch pointer (next address to be requested).

Function
REQ-016 The queue SHALL be a FIFO of {pc, instr} pairs, QDEPTH entries; id_valid = (count != 0); pop occurs when id_valid && id_ready.
REQ-017 The FSM SHALL have states IDLE (no request), BUSY (request outstanding, response kept), DRAIN (request outstanding, response discarded).
REQ-018 Once imem_req is raised, imem_req and imem_addr SHALL hold stable until the cycle in which imem_ack=1.
REQ-019 IDLE, branch_taken=1: pc_out <= target, state stays IDLE, no request issued this cycle.
REQ-020 IDLE, branch_taken=0, count < QDEPTH: imem_req <= 1, imem_addr <= pc_out, go to BUSY.
REQ-021 IDLE, branch_taken=0, count = QDEPTH: remain IDLE.
REQ-022 BUSY, imem_ack=1, branch_taken=0: push {imem_addr, imem_rdata}, pc_out <= imem_addr+4. If count after push (including a same-cycle pop) < QDEPTH, stay BUSY with imem_addr <= imem_addr+4 (back-to-back, one instruction per cycle); otherwise drop imem_req and go to IDLE.
REQ-023 BUSY, imem_ack=1, branch_taken=1: drop the response, flush the queue, pc_out <= target, imem_req <= 0, go to IDLE.
REQ-024 BUSY, imem_ack=0, branch_taken=1: flush the queue, pc_out <= target, go to DRAIN with imem_req/imem_addr unchanged.
REQ-025 DRAIN, imem_ack=1: discard the response, imem_req <= 0, go to IDLE; a same-cycle branch_taken also updates pc_out.
REQ-026 DRAIN, branch_taken=1 without ack: pc_out <= newest target (last redirect wins), remain DRAIN.
REQ-027 A flush SHALL clear count to 0 in the same edge; a pop coincident with a redirect is discarded, and id_valid SHALL be 0 the cycle after any redirect.
REQ-028 Requests SHALL only start when count < QDEPTH, so a push SHALL never occur into a full queue.
REQ-029 Address arithmetic SHALL be modulo 2^32: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
REQ-030 A simultaneous push and pop SHALL leave count unchanged and preserve order.

Reset
REQ-031 While rst=0: pc_out=RESET_VECTOR, imem_req=0, imem_addr=RESET_VECTOR, count=0, id_valid=0, id_instr=0, id_pc=0, state=IDLE, immediately (asynchronous).
REQ-032 Reset asserted mid-transaction SHALL abandon the outstanding request; any imem_ack after release while imem_req=0 SHALL be ignored.
REQ-033 The first imem_req SHALL assert on the first rising edge after rst deasserts.

Verification
REQ-034 Reset release, memory acks every cycle, id_ready=1 -> imem_addr 0,4,8,...; id_pc follows one cycle behind; one instruction per cycle.
REQ-035 id_ready=0, QDEPTH=2 -> exactly two pushes (pc 0, 4), then imem_req=0, pc_out=8; raising id_ready drains 0 then 4, and fetching resumes at 8.
REQ-036 BUSY at addr 0x10, no ack, branch_taken with target 0x40 -> queue flushed, DRAIN; ack with 0xDEADBEEF is discarded; next request at addr 0x40.
REQ-037 branch_taken in the same cycle as ack (addr 0x20) and a pop -> nothing pushed, id_valid=0 next cycle, next request at target.
REQ-038 Redirect to 0xFFFF_FFFC -> fetches 0xFFFF_FFFC then 0x0000_0000.
REQ-039 rst pulsed low while BUSY at 0x30 -> all outputs at reset values during the pulse; first request after release at RESET_VECTOR.

Source files
------------

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch with redirect handling and a small {pc, instr} queue.
module fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int QDEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  input  logic        id_ready,
  output logic [31:0] pc_out
);
  localparam int PW = QDEPTH > 1 ? $clog2(QDEPTH) : 1;
  typedef enum logic [1:0] {IDLE, BUSY, DRAIN} state_t;
  state_t state;
  logic [31:0] pcq [QDEPTH];
  logic [31:0] iq [QDEPTH];
  logic [PW-1:0] rd, wr;
  logic [2:0] count, cnt_nxt;
  logic pop, push;
  logic [31:0] tgt, nxt_addr;
  assign tgt = {branch_target[31:2], 2'b00};
  assign nxt_addr = imem_addr + 32'd4;
  assign id_valid = count != 3'd0;
  assign id_instr = iq[rd];
  assign id_pc = pcq[rd];
  assign pop = id_valid && id_ready;
  assign push = state == BUSY && imem_ack && !branch_taken;
  assign cnt_nxt = count + 3'(push) - 3'(pop);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      imem_req <= 1'b0;
      imem_addr <= RESET_VECTOR;
      pc_out <= RESET_VECTOR;
      count <= '0;
      rd <= '0;
      wr <= '0;
      for (int i = 0; i < QDEPTH; i++) begin
        pcq[i] <= '0;
        iq[i] <= '0;
      end
    end else begin
      // any redirect flushes the queue, discarding a coincident pop
      if (branch_taken) begin
        count <= '0;
        rd <= '0;
        wr <= '0;
      end else begin
        if (push) begin
          pcq[wr] <= imem_addr;
          iq[wr] <= imem_rdata;
          wr <= (wr == PW'(QDEPTH - 1)) ? '0 : wr + 1'b1;
        end
        if (pop) rd <= (rd == PW'(QDEPTH - 1)) ? '0 : rd + 1'b1;
        count <= cnt_nxt;
      end
      case (state)
        IDLE: begin
          if (branch_taken) pc_out <= tgt;
          else if (count < 3'(QDEPTH)) begin
            imem_req <= 1'b1;
            imem_addr <= pc_out;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (imem_ack && branch_taken) begin
            pc_out <= tgt;
            imem_req <= 1'b0;
            state <= IDLE;
          end else if (imem_ack) begin
            pc_out <= nxt_addr;
            if (cnt_nxt < 3'(QDEPTH)) imem_addr <= nxt_addr;
            else begin
              imem_req <= 1'b0;
              state <= IDLE;
            end
          end else if (branch_taken) begin
            pc_out <= tgt;
            state <= DRAIN;
          end
        end
        DRAIN: begin
          if (branch_taken) pc_out <= tgt;
          if (imem_ack) begin
            imem_req <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
